clic_gateway: RTL

//  Per-source interrupt gateway directly upstream of the CLIC register adapter.
//  - Synchronises raw interrupt lines and applies the trigger mode (edge or level).
//  - Keeps the edge-pending state and merges in software writes to clicintip and claim acknowledges.
//  - Drives the pending vector that the adapter writes back into clicintip every cycle.

---
 rtl/clic_pkg.sv | 17 +
 rtl/clic_sync.sv | 22 ++
 rtl/clic_gateway.sv | 82 ++++++++
 3 files changed

// File: rtl/clic_pkg.sv
// Shared types and defaults for the CLIC interrupt gateway.
package clic_pkg;

  typedef enum logic [1:0] {
    LEVEL_POS = 2'b00,
    EDGE_POS  = 2'b01,
    LEVEL_NEG = 2'b10,
    EDGE_NEG  = 2'b11
  } trig_mode_e;

  localparam int unsigned CLIC_DEFAULT_SYNC_STAGES = 2;

  function automatic logic is_edge(trig_mode_e m);
    return (m == EDGE_POS) || (m == EDGE_NEG);
  endfunction

endpackage

// File: rtl/clic_sync.sv
// One-bit multi-flop synchroniser for an asynchronous interrupt line.
module clic_sync
  import clic_pkg::*;
#(
  parameter int unsigned STAGES = CLIC_DEFAULT_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) chain <= '0;
    else         chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/clic_gateway.sv
// Per-source CLIC interrupt gateway: sync, trigger mode, pending merge.
// Build option CLIC_GATEWAY_POLARITY_EN enables active-low/falling triggers.
module clic_gateway
  import clic_pkg::*;
#(
  parameter int unsigned N_SOURCE    = 32,
  parameter int unsigned SYNC_STAGES = CLIC_DEFAULT_SYNC_STAGES,
  parameter int unsigned IdWidth     = $clog2(N_SOURCE)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SOURCE-1:0] intr_src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] pol_i,
  input  logic [N_SOURCE-1:0] ip_sw_i,
  input  logic [N_SOURCE-1:0] ip_sw_qe_i,
  input  logic                claim_vld_i,
  input  logic [IdWidth-1:0]  claim_id_i,
  output logic [N_SOURCE-1:0] ip_o
);

  logic [N_SOURCE-1:0] eff_pol;
  logic [N_SOURCE-1:0] s;
  logic [N_SOURCE-1:0] a;
  logic [N_SOURCE-1:0] prev;
  logic [N_SOURCE-1:0] rise;
  logic [N_SOURCE-1:0] ip_q;
  logic                armed;

`ifdef CLIC_GATEWAY_POLARITY_EN
  assign eff_pol = pol_i;
`else
  logic unused_pol;
  assign eff_pol    = '0;
  assign unused_pol = ^pol_i;
`endif

  assign a    = s ^ eff_pol;
  // armed masks the first post-reset cycle, when prev is still 0
  assign rise = a & ~prev & {N_SOURCE{armed}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      prev  <= a;
      armed <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
    trig_mode_e mode;
    logic       hit;
    logic       ip_r;

    clic_sync #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d     (intr_src_i[i]),
      .q     (s[i])
    );

    assign mode = trig_mode_e'({eff_pol[i], le_i[i]});
    assign hit  = claim_vld_i && (32'(claim_id_i) == i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)              ip_r <= 1'b0;
      else if (!is_edge(mode))  ip_r <= a[i];
      else if (rise[i])         ip_r <= 1'b1;
      else if (ip_sw_qe_i[i])   ip_r <= ip_sw_i[i];
      else if (hit)             ip_r <= 1'b0;
    end

    assign ip_q[i] = ip_r;
  end

  assign ip_o = ip_q;

endmodule
